// File: rtl/regfile_pkg.sv
// Shared types and default constants for the multi-port register file.
// Top-level instantiations pick up the stack-pointer defaults from here.
package regfile_pkg;

  typedef enum logic {IDLE, CLEAR} rf_state_t;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h10010200;
  localparam int          SP_IDX_DEFAULT  = 29;
  localparam int          CLR_IDX_W       = 6;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Soft-clear sequencer: walks every register index once, one per cycle,
// and drops ready while the sweep is in progress.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int                NUM_REGS = 32,
  parameter int                DATA_W   = 32,
  parameter int                SP_IDX   = SP_IDX_DEFAULT,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 ready,
  output logic                 clr_active,
  output logic [CLR_IDX_W-1:0] clr_idx,
  output logic [DATA_W-1:0]    clr_wdata
);

  localparam logic [CLR_IDX_W-1:0] LAST_IDX = CLR_IDX_W'(NUM_REGS - 1);
  localparam logic [CLR_IDX_W-1:0] SP_IDX_C = CLR_IDX_W'(SP_IDX);

  rf_state_t             state_q, state_d;
  logic [CLR_IDX_W-1:0]  idx_q, idx_d;
  logic                  ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
          ready_d = 1'b0;
        end
      end
      CLEAR: begin
        // clr_req is deliberately not looked at here: a request mid-sweep is dropped
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign clr_active = (state_q == CLEAR);
  assign clr_idx    = idx_q;
  assign clr_wdata  = (idx_q == SP_IDX_C) ? SP_INIT : '0;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports plus a dedicated $v0 port, hardwired zero register, optional bypass.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter int                ADDR_W   = $clog2(NUM_REGS),
  parameter int                NUM_RD   = 2,
  parameter int                BYPASS   = 1,
  parameter int                SP_IDX   = SP_IDX_DEFAULT,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEFAULT),
  parameter int                V0_IDX   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_req,
  output logic                          ready,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0]             v0_data,
  input  logic [1:0]                    wr_en,
  input  logic [1:0][ADDR_W-1:0]        wr_addr,
  input  logic [1:0][DATA_W-1:0]        wr_data
);

  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);
  localparam int              NUM_LK     = NUM_RD + 1;

  logic                 clr_active;
  logic [CLR_IDX_W-1:0] clr_idx;
  logic [DATA_W-1:0]    clr_wdata;
  logic [1:0]           wr_ok;
  logic [DATA_W-1:0]    reg_vals [NUM_REGS];
  logic [ADDR_W-1:0]    lk_addr  [NUM_LK];
  logic [DATA_W-1:0]    lk_data  [NUM_LK];

  regfile_clr_fsm #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .SP_IDX   (SP_IDX),
    .SP_INIT  (SP_INIT)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .ready      (ready),
    .clr_active (clr_active),
    .clr_idx    (clr_idx),
    .clr_wdata  (clr_wdata)
  );

  // A write port is live only in IDLE and only for a real, nonzero register;
  // the same qualifier gates storage updates and forwarding.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_wr_ok
    assign wr_ok[gi] = !clr_active && wr_en[gi] && (wr_addr[gi] != '0) &&
                       ({1'b0, wr_addr[gi]} < NUM_REGS_C);
  end

  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign reg_vals[gi] = '0;
    end else begin : g_store
      localparam logic [DATA_W-1:0] RST_VAL = (gi == SP_IDX) ? SP_INIT : '0;
      logic [DATA_W-1:0] val_q, val_d;

      always_comb begin
        val_d = val_q;
        if (clr_active) begin
          if (clr_idx == CLR_IDX_W'(gi)) val_d = clr_wdata;
        end else if (wr_ok[1] && (wr_addr[1] == ADDR_W'(gi))) begin
          val_d = wr_data[1];
        end else if (wr_ok[0] && (wr_addr[0] == ADDR_W'(gi))) begin
          val_d = wr_data[0];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) val_q <= RST_VAL;
        else      val_q <= val_d;
      end

      assign reg_vals[gi] = val_q;
    end
  end

  // The $v0 port is just one extra lookup slot with a constant address.
  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
    assign lk_addr[gi] = rd_addr[gi];
    assign rd_data[gi] = lk_data[gi];
  end
  assign lk_addr[NUM_RD] = ADDR_W'(V0_IDX);
  assign v0_data         = lk_data[NUM_RD];

  for (gi = 0; gi < NUM_LK; gi++) begin : g_lookup
    logic [DATA_W-1:0] stored, fwd;

    always_comb begin
      stored = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (lk_addr[gi] == ADDR_W'(r)) stored = reg_vals[r];
      end
    end

    // Port 1 is checked last so it overrides port 0 on a double match.
    always_comb begin
      fwd = stored;
      if (BYPASS != 0) begin
        if (wr_ok[0] && (wr_addr[0] == lk_addr[gi])) fwd = wr_data[0];
        if (wr_ok[1] && (wr_addr[1] == lk_addr[gi])) fwd = wr_data[1];
      end
    end

    assign lk_data[gi] = fwd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a 32-entry bypassing instance and a 40-entry
// non-bypassing instance, checked through an expected-value queue.
module tb_register_file_mp;

  localparam logic [31:0] SP = 32'h10010200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             a_clr, a_ready;
  logic [1:0][4:0]  a_ra, a_wa;
  logic [1:0][31:0] a_rd, a_wd;
  logic [31:0]      a_v0;
  logic [1:0]       a_we;

  logic             b_clr, b_ready;
  logic [1:0][5:0]  b_ra, b_wa;
  logic [1:0][31:0] b_rd, b_wd;
  logic [31:0]      b_v0;
  logic [1:0]       b_we;

  register_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .clr_req(a_clr), .ready(a_ready),
    .rd_addr(a_ra), .rd_data(a_rd), .v0_data(a_v0),
    .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd)
  );

  register_file_mp #(.DATA_W(32), .NUM_REGS(40), .NUM_RD(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .clr_req(b_clr), .ready(b_ready),
    .rd_addr(b_ra), .rd_data(b_rd), .v0_data(b_v0),
    .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1, e_v0;
  } vec_t;

  typedef struct {
    string       name;
    int          src;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs [12];
  sb_t  sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int src);
    case (src)
      0:       return a_rd[0];
      1:       return a_rd[1];
      2:       return a_v0;
      3:       return {31'b0, a_ready};
      4:       return b_rd[0];
      5:       return b_rd[1];
      6:       return b_v0;
      7:       return {31'b0, b_ready};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string name, input int src, input logic [31:0] exp);
    sb_t t;
    t.name = name;
    t.src  = src;
    t.exp  = exp;
    sb_q.push_back(t);
  endtask

  // Outputs are combinational; compare everything pending at the falling edge.
  task automatic drain();
    sb_t t;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      check(t.name, probe(t.src), t.exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    a_we  = 2'b00;
    a_clr = 1'b0;
    b_we  = 2'b00;
    b_clr = 1'b0;
  endtask

  task automatic sweep_a(input string tag);
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      a_ra[0] = 5'(2 * k);
      a_ra[1] = 5'(2 * k + 1);
      push($sformatf("%s_r%0d", tag, 2 * k),     0, (2 * k == 29)     ? SP : 32'h0);
      push($sformatf("%s_r%0d", tag, 2 * k + 1), 1, (2 * k + 1 == 29) ? SP : 32'h0);
      drain();
    end
    $display("sweep %s done at %0t", tag, $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_low;

    vecs[0]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         5'd29, 5'd0,  SP,            32'h0,         32'h0};
    vecs[1]  = '{2'b11, 5'd5, 5'd5, 32'hAAAA_AAAA, 32'h5555_5555, 5'd5,  5'd7,  32'h5555_5555, 32'h0,         32'h0};
    vecs[2]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         5'd5,  5'd29, 32'h5555_5555, SP,            32'h0};
    vecs[3]  = '{2'b01, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0,         5'd0,  5'd5,  32'h0,         32'h5555_5555, 32'h0};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         5'd0,  5'd1,  32'h0,         32'h0,         32'h0};
    vecs[5]  = '{2'b11, 5'd7, 5'd8, 32'h1111_2222, 32'h3333_4444, 5'd7,  5'd8,  32'h1111_2222, 32'h3333_4444, 32'h0};
    vecs[6]  = '{2'b10, 5'd7, 5'd8, 32'h0000_0099, 32'h0BAD_F00D, 5'd7,  5'd8,  32'h1111_2222, 32'h0BAD_F00D, 32'h0};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         5'd7,  5'd8,  32'h1111_2222, 32'h0BAD_F00D, 32'h0};
    vecs[8]  = '{2'b01, 5'd2, 5'd0, 32'h0000_00C8, 32'h0,         5'd3,  5'd2,  32'h0,         32'h0000_00C8, 32'h0000_00C8};
    vecs[9]  = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         5'd2,  5'd5,  32'h0000_00C8, 32'h5555_5555, 32'h0000_00C8};
    vecs[10] = '{2'b11, 5'd9, 5'd9, 32'h0000_0001, 32'h0000_0002, 5'd9,  5'd29, 32'h0000_0002, SP,            32'h0000_00C8};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         5'd9,  5'd31, 32'h0000_0002, 32'h0,         32'h0000_00C8};

    rst   = 1'b0;
    a_clr = 1'b0; a_we = 2'b00; a_ra = '0; a_wa = '0; a_wd = '0;
    b_clr = 1'b0; b_we = 2'b00; b_ra = '0; b_wa = '0; b_wd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_a", {31'b0, a_ready}, 32'h1);
    check("rst_ready_b", {31'b0, b_ready}, 32'h1);
    check("rst_v0_a", a_v0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    sweep_a("reset");

    // Table-driven write/read/bypass vectors on the bypassing instance
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      a_we    = vecs[i].we;
      a_wa[0] = vecs[i].wa0;
      a_wa[1] = vecs[i].wa1;
      a_wd[0] = vecs[i].wd0;
      a_wd[1] = vecs[i].wd1;
      a_ra[0] = vecs[i].ra0;
      a_ra[1] = vecs[i].ra1;
      push($sformatf("vec%0d_rd0", i),   0, vecs[i].e_rd0);
      push($sformatf("vec%0d_rd1", i),   1, vecs[i].e_rd1);
      push($sformatf("vec%0d_v0", i),    2, vecs[i].e_v0);
      push($sformatf("vec%0d_ready", i), 3, 32'h1);
      drain();
      $display("vec %0d we=%b wa=%0d/%0d ra=%0d/%0d rd=%h/%h v0=%h",
               i, a_we, a_wa[0], a_wa[1], a_ra[0], a_ra[1], a_rd[0], a_rd[1], a_v0);
    end

    // Non-bypassing 40-entry instance: discarded writes and next-cycle visibility
    next_cycle();
    b_we = 2'b11; b_wa[0] = 6'd40; b_wd[0] = 32'hDEAD_BEEF; b_wa[1] = 6'd0; b_wd[1] = 32'hDEAD_BEEF;
    b_ra[0] = 6'd40; b_ra[1] = 6'd0;
    push("b_oor_same_rd0", 4, 32'h0);
    push("b_zero_same_rd1", 5, 32'h0);
    drain();
    next_cycle();
    b_we = 2'b11; b_wa[0] = 6'd2; b_wd[0] = 32'h0000_00C8; b_wa[1] = 6'd39; b_wd[1] = 32'h0000_0039;
    b_ra[0] = 6'd2; b_ra[1] = 6'd39;
    push("b_nobyp_rd0", 4, 32'h0);
    push("b_nobyp_rd1", 5, 32'h0);
    push("b_nobyp_v0", 6, 32'h0);
    drain();
    next_cycle();
    b_ra[0] = 6'd2; b_ra[1] = 6'd39;
    push("b_next_rd0", 4, 32'h0000_00C8);
    push("b_next_rd1", 5, 32'h0000_0039);
    push("b_next_v0", 6, 32'h0000_00C8);
    drain();
    for (int k = 0; k < 32; k++) begin
      next_cycle();
      b_ra[0] = 6'(2 * k);
      b_ra[1] = 6'(2 * k + 1);
      for (int p = 0; p < 2; p++) begin
        int          r;
        logic [31:0] e;
        r = 2 * k + p;
        e = (r == 29) ? SP : (r == 2) ? 32'h0000_00C8 : (r == 39) ? 32'h0000_0039 : 32'h0;
        push($sformatf("b_sweep_r%0d", r), 4 + p, e);
      end
      drain();
    end
    $display("sweep b done at %0t", $time);

    // Fill, then soft-clear with a write on the request edge and one mid-sweep
    for (int k = 1; k < 32; k++) begin
      next_cycle();
      a_we = 2'b01; a_wa[0] = 5'(k); a_wd[0] = 32'hA000_0000 + 32'(k);
    end
    next_cycle();
    a_we = 2'b01; a_wa[0] = 5'd31; a_wd[0] = 32'hFEED_FACE; a_clr = 1'b1;
    a_ra[0] = 5'd31; a_ra[1] = 5'd1;
    push("clr_req_ready", 3, 32'h1);
    drain();
    next_cycle();
    n_low = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (a_ready) break;
      n_low++;
      if (n_low == 1) begin
        check("clr_edge_write_r31", a_rd[0], 32'hFEED_FACE);
        check("clr_partial_r1", a_rd[1], 32'hA000_0001);
      end
      if (n_low == 11) check("clr_write_lost_r3", a_rd[0], 32'h0);
      next_cycle();
      if (n_low == 10) begin
        a_we = 2'b01; a_wa[0] = 5'd3; a_wd[0] = 32'h0000_0077; a_ra[0] = 5'd3;
      end
      if (n_low == 20) a_clr = 1'b1;
    end
    check("clr_ready_low_cycles", 32'(n_low), 32'd32);
    $display("clear finished after %0d cycles at %0t", n_low, $time);
    sweep_a("after_clr");

    // Reset asserted in the middle of a clear sweep
    next_cycle();
    a_we = 2'b11; a_wa[0] = 5'd3; a_wd[0] = 32'h0000_0055; a_wa[1] = 5'd31; a_wd[1] = 32'h0000_0031;
    next_cycle();
    a_we = 2'b01; a_wa[0] = 5'd2; a_wd[0] = 32'h0000_0202;
    next_cycle();
    push("pre_rst_v0", 2, 32'h0000_0202);
    drain();
    next_cycle();
    a_clr = 1'b1;
    next_cycle();
    a_ra[0] = 5'd31; a_ra[1] = 5'd29;
    repeat (10) @(posedge clk);
    #1;
    check("mid_clr_ready", {31'b0, a_ready}, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_ready", {31'b0, a_ready}, 32'h1);
    check("rst_async_r31", a_rd[0], 32'h0);
    check("rst_async_r29", a_rd[1], SP);
    check("rst_async_v0", a_v0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    a_we = 2'b01; a_wa[0] = 5'd3; a_wd[0] = 32'h0000_1234;
    a_ra[0] = 5'd3; a_ra[1] = 5'd31;
    next_cycle();
    push("post_rst_r3", 0, 32'h0000_1234);
    push("post_rst_r31", 1, 32'h0);
    push("post_rst_ready", 3, 32'h1);
    push("post_rst_v0", 2, 32'h0);
    drain();
    next_cycle();
    a_ra[1] = 5'd29;
    push("post_rst_ready2", 3, 32'h1);
    push("post_rst_r29", 1, SP);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the MIPS multi-cycle datapath. It is the next generation of the 32x32 single-write register file and adds the following:

- configurable width, depth and read-port count;
- two write ports with fixed priority;
- a hardwired zero register;
- optional write-to-read bypass;
- a sequenced soft-clear with a ready handshake.

It sits between the decode and writeback stages. The dedicated $v0 read port still feeds the syscall/debug path.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (2..64; need not be a power of 2)
- ADDR_W, $clog2(NUM_REGS), register address width
- NUM_RD, 2, number of general read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
- SP_IDX, 29, index of the stack-pointer register
- SP_INIT, 32'h10010200, value loaded into SP_IDX on reset and on clear
- V0_IDX, 2, index presented on v0_data

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr_req  in  1  soft-clear request, sampled at posedge
- ready  out  1  1 = IDLE, writes accepted
- rd_addr  in  NUM_RD x ADDR_W  read addresses
- rd_data  out  NUM_RD x DATA_W  read data (combinational)
- v0_data  out  DATA_W  contents of V0_IDX (combinational, includes bypass)
- wr_en  in  2  write enables, port 0 and port 1
- wr_addr  in  2 x ADDR_W  write addresses
- wr_data  in  2 x DATA_W  write data

## Operation

Storage and reads:
- Storage holds NUM_REGS x DATA_W registers.
- Register 0 always reads 0. Writes to it are discarded.
- Any address >= NUM_REGS reads 0. Writes to such an address are discarded.
- Reads are combinational: rd_data[i] = reg[rd_addr[i]].

Writes:
- In IDLE, each port with wr_en set commits wr_data to wr_addr at posedge.
- If both ports target the same address, port 1 wins and port 0's write is dropped.

Bypass (BYPASS=1):
- Applies when a read address equals an enabled, in-range, nonzero write address in the same cycle.
- The read returns that wr_data. When both ports match, port 1's data is returned.
- v0_data bypasses under the same rule.
- With BYPASS=0, reads return pre-write contents.

Clear FSM (states IDLE, CLEAR):
- IDLE -> CLEAR when clr_req=1 at posedge. A 6-bit index clr_idx loads 0.
- In CLEAR, each cycle writes 0 to reg[clr_idx] (SP_INIT if clr_idx==SP_IDX), then increments clr_idx.
- CLEAR -> IDLE at the posedge that clears index NUM_REGS-1.
- In CLEAR, ready=0 and wr_en is ignored (the writes are lost, not queued). clr_req is ignored.
- Reads in CLEAR return current contents: partially cleared, no bypass.
- A simultaneous clr_req and wr_en in IDLE: the write commits, and the clear starts the same edge.

Reset:
- Asserting rst, including mid-CLEAR, immediately forces the following:
  - all registers to 0, except SP_IDX = SP_INIT;
  - state IDLE, clr_idx 0, ready=1.
- rd_data and v0_data then reflect the reset contents (v0_data = 0 unless V0_IDX==SP_IDX).

## Timing

- Write latency: 1 cycle; visible on reads in the next cycle, or in the same cycle with BYPASS=1.
- Clear duration: exactly NUM_REGS cycles with ready=0. ready rises in the cycle after the last clear write.
- No output registers. Read path is a NUM_REGS:1 mux plus a 2-level bypass mux.
- Reset release is synchronous to the next posedge; first write is accepted at that edge.

## Structure

- Shared package regfile_pkg holds:
  - typedef enum logic {IDLE, CLEAR} rf_state_t;
  - localparams SP_INIT_DEFAULT = 32'h10010200 and SP_IDX_DEFAULT = 29, for use by top-level instantiations.
- One sub-module, regfile_clr_fsm, owns the state, clr_idx and ready. It outputs clr_active, clr_idx and clr_wdata.
- The top holds storage, write-priority logic, read muxes and bypass.

## Test plan

- Reset then read all registers -> every register reads 0 except reg29 = 32'h10010200. ready=1.
- wr_en=2'b11, both wr_addr=5, wr_data0=32'hAAAA_AAAA, wr_data1=32'h5555_5555 -> reg5 = 32'h5555_5555. With BYPASS=1, rd_addr0=5 returns 32'h5555_5555 in the same cycle.
- Write 32'hDEAD_BEEF to reg0, and to address 40 with NUM_REGS=40 -> both read 0, and no other register changes.
- Fill reg1..31 with nonzero values, pulse clr_req -> ready=0 for exactly 32 cycles. A write issued mid-clear is lost. Afterwards all registers are 0 except reg29 = SP_INIT.
- Assert rst at clear cycle 10 -> on reset assertion, ready=1 and state IDLE. After release, contents equal reset values, and a write of 32'h1234 to reg3 on the first edge reads back.
- Write 32'h0000_00C8 to reg2 -> v0_data = 32'hC8 in the same cycle (BYPASS=1) or the next cycle (BYPASS=0).
